// File: rtl/lcd_frame_capture_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  lcd_frame_capture_if
//  Pixel-stream bundle from the video unit into the frame capture block.
//  Revision: 1.0
// ============================================================================
interface lcd_frame_capture_if #(
    parameter int PIXEL_BITS = 2
);
    logic                  pix_valid;
    logic [PIXEL_BITS-1:0] pix_data;
    logic                  frame_start;

    modport master (output pix_valid, pix_data, frame_start);
    modport slave  (input  pix_valid, pix_data, frame_start);
endinterface
`default_nettype wire

// File: rtl/lcd_frame_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  lcd_frame_capture
//  Assembles the raster pixel stream into a frame buffer with a registered
//  read port and framing checks. LCD_CAPTURE_DOUBLE_BUFFER_EN adds a 2nd bank.
//  Revision: 1.0
// ============================================================================
module lcd_frame_capture #(
    parameter int LINE_WIDTH = 160,
    parameter int LINES      = 144,
    parameter int PIXEL_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_frame_capture_if.slave    pix,
    input  logic [14:0]           rd_addr,
    output logic [PIXEL_BITS-1:0] rd_data,
    output logic                  rd_bank,
    output logic                  frame_done,
    output logic [7:0]            frame_count,
    output logic                  capture_busy,
    output logic                  err_sync,
    input  logic                  err_clr
);

    localparam int c_DEPTH = LINE_WIDTH * LINES;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    localparam int c_NUM_BANKS = 2;
`else
    localparam int c_NUM_BANKS = 1;
`endif
    localparam int c_MEM_AW = $clog2(c_NUM_BANKS * c_DEPTH);
    localparam int c_X_W    = $clog2(LINE_WIDTH);
    localparam int c_Y_W    = $clog2(LINES);
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(LINE_WIDTH - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(LINES - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CAPTURE = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_X_W-1:0]      r_x, w_x_nxt, w_wr_x;
    logic [c_Y_W-1:0]      r_y, w_y_nxt, w_wr_y;
    logic                  w_wr_en, w_err_set, w_frame_end;
    logic                  w_rd_bank, w_wr_bank;
    logic                  r_frame_done, r_err_sync;
    logic [7:0]            r_frame_count;
    logic [PIXEL_BITS-1:0] r_rd_data;
    logic [c_MEM_AW-1:0]   w_wr_idx, w_rd_idx;
    logic                  w_rd_in_range;

    logic [PIXEL_BITS-1:0] r_mem [0:c_NUM_BANKS*c_DEPTH-1];

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_wr_x      = r_x;
        w_wr_y      = r_y;
        w_wr_en     = 1'b0;
        w_err_set   = 1'b0;
        w_frame_end = 1'b0;
        if (pix.pix_valid) begin
            if (pix.frame_start) begin
                // A frame_start mid-capture restarts at (0,0) in the same bank
                w_err_set   = (r_state == S_CAPTURE);
                w_wr_en     = 1'b1;
                w_wr_x      = '0;
                w_wr_y      = '0;
                w_x_nxt     = c_X_W'(1);
                w_y_nxt     = '0;
                w_state_nxt = S_CAPTURE;
            end else if (r_state == S_IDLE) begin
                w_err_set = 1'b1;
            end else begin
                w_wr_en = 1'b1;
                if (r_x == c_X_LAST) begin
                    w_x_nxt = '0;
                    if (r_y == c_Y_LAST) begin
                        w_y_nxt     = '0;
                        w_frame_end = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_y_nxt = r_y + c_Y_W'(1);
                    end
                end else begin
                    w_x_nxt = r_x + c_X_W'(1);
                end
            end
        end
    end

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    logic r_rd_bank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_bank <= 1'b1;
        end else if (w_frame_end) begin
            r_rd_bank <= ~r_rd_bank;
        end
    end

    assign w_rd_bank = r_rd_bank;
    assign w_wr_bank = ~r_rd_bank;
`else
    assign w_rd_bank = 1'b0;
    assign w_wr_bank = 1'b0;
`endif

    assign w_wr_idx      = c_MEM_AW'(int'(w_wr_bank) * c_DEPTH + int'(w_wr_y) * LINE_WIDTH + int'(w_wr_x));
    assign w_rd_idx      = c_MEM_AW'(int'(w_rd_bank) * c_DEPTH + int'(rd_addr));
    assign w_rd_in_range = (int'(rd_addr) < c_DEPTH);

    // Storage carries no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= pix.pix_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 8'd0;
            r_err_sync    <= 1'b0;
            r_rd_data     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_err_set) begin
                r_err_sync <= 1'b1;
            end else if (err_clr) begin
                r_err_sync <= 1'b0;
            end
            r_rd_data <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_bank      = w_rd_bank;
    assign frame_done   = r_frame_done;
    assign frame_count  = r_frame_count;
    assign capture_busy = (r_state == S_CAPTURE);
    assign err_sync     = r_err_sync;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_lcd_frame_capture
//  Randomized bench with a pixel-index reference model of the frame buffer.
//  Revision: 1.0
// ============================================================================
module tb_lcd_frame_capture;

    localparam int LW    = 10;
    localparam int LN    = 6;
    localparam int PB    = 2;
    localparam int DEPTH = LW * LN;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [14:0]   rd_addr;
    logic [PB-1:0] rd_data;
    logic          rd_bank, frame_done, capture_busy, err_sync;
    logic          err_clr;
    logic [7:0]    frame_count;

    lcd_frame_capture_if #(.PIXEL_BITS(PB)) pif ();

    lcd_frame_capture #(
        .LINE_WIDTH (LW),
        .LINES      (LN),
        .PIXEL_BITS (PB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pix          (pif),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_bank      (rd_bank),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .capture_busy (capture_busy),
        .err_sync     (err_sync),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: frame progress tracked as a linear pixel index
    bit m_in_frame;
    int m_p;
    bit m_rd_bank;
    int m_count;
    bit m_err;
    bit m_done;
    int m_mem [2][DEPTH];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_p        = 0;
        m_rd_bank  = DB;
        m_count    = 0;
        m_err      = 1'b0;
        m_done     = 1'b0;
    endtask

    function automatic int exp_read(input int addr);
        if (addr >= DEPTH) return 0;
        return m_mem[m_rd_bank][addr];
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_done"},  int'(frame_done),   int'(m_done));
        check({tag, "_count"}, int'(frame_count),  m_count);
        check({tag, "_busy"},  int'(capture_busy), int'(m_in_frame));
        check({tag, "_err"},   int'(err_sync),     int'(m_err));
        check({tag, "_bank"},  int'(rd_bank),      int'(m_rd_bank));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"}, int'(rd_data),      0);
        check({tag, "_rd_bank"}, int'(rd_bank),      int'(DB));
        check({tag, "_done"},    int'(frame_done),   0);
        check({tag, "_count"},   int'(frame_count),  0);
        check({tag, "_busy"},    int'(capture_busy), 0);
        check({tag, "_err"},     int'(err_sync),     0);
    endtask

    // One clock: drive at negedge, update model after posedge, check at negedge
    task automatic beat(input bit v, input bit fs, input int d, input bit clr, input int raddr);
        int er;
        int wb;
        bit set;
        pif.pix_valid   = v;
        pif.frame_start = fs;
        pif.pix_data    = PB'(d);
        err_clr         = clr;
        rd_addr         = 15'(raddr);
        er              = exp_read(raddr);
        @(posedge clk);
        set    = 1'b0;
        m_done = 1'b0;
        wb     = (DB && !m_rd_bank) ? 1 : 0;
        if (v) begin
            if (fs) begin
                set            = m_in_frame;
                m_mem[wb][0]   = d;
                m_p            = 1;
                m_in_frame     = 1'b1;
            end else if (!m_in_frame) begin
                set = 1'b1;
            end else begin
                m_mem[wb][m_p] = d;
                m_p++;
                if (m_p == DEPTH) begin
                    m_done     = 1'b1;
                    m_count    = (m_count + 1) % 256;
                    m_in_frame = 1'b0;
                    if (DB) m_rd_bank = !m_rd_bank;
                end
            end
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        @(negedge clk);
        if (er >= 0) check("rd_data", int'(rd_data), er);
        check_status("beat");
    endtask

    function automatic int rand_addr();
        return int'($urandom_range(0, DEPTH + 3));
    endfunction

    // mode: 0 = (x+y)%4, 1 = constant 3, 2 = random; stall: 0 none, 1 alternate, 2 random
    task automatic send_frame(input int mode, input int stall);
        for (int i = 0; i < DEPTH; i++) begin
            int d;
            if (mode == 0)      d = ((i % LW) + (i / LW)) % 4;
            else if (mode == 1) d = 3;
            else                d = int'($urandom_range(0, 3));
            if (stall == 1 && i > 0) beat(1'b0, 1'b0, 0, 1'b0, rand_addr());
            if (stall == 2 && $urandom_range(0, 9) == 0) beat(1'b0, 1'b0, 0, 1'b0, rand_addr());
            beat(1'b1, i == 0, d, 1'b0, rand_addr());
        end
    endtask

    task automatic read_expect(input string tag, input int addr, input int exp);
        beat(1'b0, 1'b0, 0, 1'b0, addr);
        check(tag, int'(rd_data), exp);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) m_mem[b][a] = -1;
        model_reset();
        pif.pix_valid   = 1'b0;
        pif.frame_start = 1'b0;
        pif.pix_data    = '0;
        err_clr         = 1'b0;
        rd_addr         = '0;
        @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;

        // Full frame of (x+y)%4 with continuous valid
        send_frame(0, 0);
        check("t1_done_pulse", int'(frame_done), 1);
        check("t1_count", int'(frame_count), 1);
        check("t1_bank", int'(rd_bank), 0);
        read_expect("t1_addr_lw_plus1", LW + 1, 2);
        check("t1_done_gone", int'(frame_done), 0);
        read_expect("t1_addr_last", DEPTH - 1, ((LW - 1) + (LN - 1)) % 4);
        read_expect("t1_addr_oob", DEPTH, 0);

        // Same frame with valid low every other cycle
        send_frame(0, 1);
        check("t2_count", int'(frame_count), 2);
        for (int a = 0; a < DEPTH; a++)
            read_expect("t2_readback", a, ((a % LW) + (a / LW)) % 4);

        // Sync error set / clear / set-wins-over-clear
        beat(1'b1, 1'b0, 1, 1'b0, rand_addr());
        check("t3_err_set", int'(err_sync), 1);
        check("t3_idle", int'(capture_busy), 0);
        beat(1'b0, 1'b0, 0, 1'b1, rand_addr());
        check("t3_err_clr", int'(err_sync), 0);
        beat(1'b1, 1'b0, 2, 1'b1, rand_addr());
        check("t3_err_set_wins", int'(err_sync), 1);
        beat(1'b0, 1'b0, 0, 1'b1, rand_addr());

        // Early restart part-way through a frame
        beat(1'b1, 1'b1, int'($urandom_range(0, 3)), 1'b0, rand_addr());
        for (int i = 1; i < 30; i++) beat(1'b1, 1'b0, int'($urandom_range(0, 3)), 1'b0, rand_addr());
        beat(1'b1, 1'b1, int'($urandom_range(0, 3)), 1'b0, rand_addr());
        check("t4_restart_err", int'(err_sync), 1);
        check("t4_no_done", int'(frame_done), 0);
        check("t4_busy", int'(capture_busy), 1);
        for (int i = 1; i < DEPTH; i++) beat(1'b1, 1'b0, int'($urandom_range(0, 3)), 1'b0, rand_addr());
        check("t4_count", int'(frame_count), 3);
        beat(1'b0, 1'b0, 0, 1'b1, rand_addr());

        // Constant-3 frame: previous frame stays readable when double buffered
        send_frame(1, 0);
        check("t5_count", int'(frame_count), 4);

        // Back-to-back random frames until the counter wraps
        for (int f = 4; f < 256; f++) send_frame(2, 2);
        check("t6_wrap", int'(frame_count), 0);
        check("t6_bank", int'(rd_bank), int'(DB));

        // Asynchronous reset mid-frame
        beat(1'b1, 1'b1, int'($urandom_range(0, 3)), 1'b0, rand_addr());
        for (int i = 1; i < 20; i++) beat(1'b1, 1'b0, int'($urandom_range(0, 3)), 1'b0, rand_addr());
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        send_frame(2, 0);
        check("t7_count", int'(frame_count), 1);
        check("t7_bank", int'(rd_bank), 0);
        for (int a = 0; a < DEPTH; a++) beat(1'b0, 1'b0, 0, 1'b0, a);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
